// File: rtl/quick_spi_target.sv
// quick_spi_target: SPI target (SCLK idles high, shift on fall, sample on rise, MSB first) with ready/valid TX/RX streams
module quick_spi_target #(
    parameter int MAX_DATA_LENGTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter logic [MAX_DATA_LENGTH-1:0] IDLE_TX_WORD = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               txdata_valid_i,
    output logic                               txdata_ready_o,
    input  logic [MAX_DATA_LENGTH-1:0]         txdata_i,
    output logic                               rxdata_valid_o,
    input  logic                               rxdata_ready_i,
    output logic [MAX_DATA_LENGTH-1:0]         rxdata_o,
    output logic [$clog2(MAX_DATA_LENGTH+1)-1:0] rxdata_len_o,
    output logic                               rx_overflow_o,
    output logic                               tx_underrun_o,
    input  logic                               sclk_i,
    input  logic                               cs_n_i,
    input  logic                               sdata_i,
    output logic                               sdata_o,
    output logic                               sdata_oe_o
);
    localparam int LW = $clog2(MAX_DATA_LENGTH+1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                     r_state, w_state_next;
    logic [SYNC_STAGES-1:0]     r_sclk_sync, r_cs_sync, r_sd_sync;
    logic                       r_sclk_q, r_cs_q;
    logic [MAX_DATA_LENGTH-1:0] r_tx_hold, r_tx_shift, r_rx_shift, r_rx_data;
    logic                       r_tx_full, r_armed, r_oe, r_rx_valid, r_overflow, r_underrun;
    logic [LW-1:0]              r_count, r_rx_len;
    logic                       w_sclk, w_cs, w_sdata;
    logic                       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic                       w_active, w_post;
    logic [MAX_DATA_LENGTH-1:0] w_rx_next;
    logic [LW-1:0]              w_cnt_next;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sdata     = r_sd_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_q;
    assign w_sclk_fall = ~w_sclk & r_sclk_q;
    assign w_cs_fall   = ~w_cs & r_cs_q;
    assign w_cs_rise   = w_cs & ~r_cs_q;
    assign w_active    = (r_state == ACTIVE);
    // A rise coinciding with CS rise must be folded into the posted result
    assign w_rx_next   = (w_active && w_sclk_rise) ? {r_rx_shift[MAX_DATA_LENGTH-2:0], w_sdata} : r_rx_shift;
    assign w_cnt_next  = (w_active && w_sclk_rise && r_count != LW'(MAX_DATA_LENGTH)) ? r_count + 1'b1 : r_count;
    assign w_post      = w_active && w_cs_rise && (w_cnt_next != '0);

    assign txdata_ready_o = ~r_tx_full;
    assign rxdata_valid_o = r_rx_valid;
    assign rxdata_o       = r_rx_data;
    assign rxdata_len_o   = r_rx_len;
    assign rx_overflow_o  = r_overflow;
    assign tx_underrun_o  = r_underrun;
    assign sdata_oe_o     = r_oe;
    assign sdata_o        = r_oe & r_tx_shift[MAX_DATA_LENGTH-1];

    // Synchronize SPI pins into clk_i and keep previous values for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_sd_sync   <= '0;
            r_sclk_q    <= 1'b1;
            r_cs_q      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_i};
            r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], sdata_i};
            r_sclk_q    <= w_sclk;
            r_cs_q      <= w_cs;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Next state: CS fall selects, CS rise deselects
    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE && w_cs_fall) w_state_next = ACTIVE;
        if (r_state == ACTIVE && w_cs_rise) w_state_next = IDLE;
    end

    // TX holding/shift registers and RX shift/count while selected
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_hold  <= '0;
            r_tx_full  <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_count    <= '0;
            r_armed    <= 1'b0;
            r_oe       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!w_active && w_cs_fall) begin
                r_tx_shift <= r_tx_full ? r_tx_hold : IDLE_TX_WORD;
                r_underrun <= ~r_tx_full;
                r_tx_full  <= 1'b0;
                r_count    <= '0;
                r_armed    <= 1'b0;
                r_oe       <= 1'b1;
            end
            if (txdata_valid_i && !r_tx_full) begin
                r_tx_hold <= txdata_i;
                r_tx_full <= 1'b1;
            end
            if (w_active) begin
                r_rx_shift <= w_rx_next;
                r_count    <= w_cnt_next;
                if (w_sclk_rise) r_armed <= 1'b1;
                if (w_sclk_fall && r_armed) r_tx_shift <= {r_tx_shift[MAX_DATA_LENGTH-2:0], 1'b0};
                if (w_cs_rise) begin
                    r_oe    <= 1'b0;
                    r_armed <= 1'b0;
                end
            end
        end
    end

    // RX output register: post on CS rise, drop and flag if the old result is still pending
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_data  <= '0;
            r_rx_len   <= '0;
            r_rx_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (w_post) begin
                if (r_rx_valid && !rxdata_ready_i) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_rx_data  <= w_rx_next;
                    r_rx_len   <= w_cnt_next;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rxdata_ready_i) begin
                r_rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_quick_spi_target.sv
// tb_quick_spi_target: directed bench with a bit-banged SPI initiator (SCLK period 8 clk)
module tb_quick_spi_target;
    logic        clk = 0, rst_n = 0;
    logic        tx_valid = 0, rx_ready = 0;
    logic [15:0] tx_data = 0;
    logic        tx_ready, rx_valid, rx_ovf, tx_und, sdo, sdo_oe;
    logic [15:0] rx_data;
    logic [4:0]  rx_len;
    logic        sclk = 1, cs_n = 1, sdi = 0;
    int          n_cmp = 0, n_bad = 0, n_under = 0, n_ovf = 0;
    int          u0, o0;
    logic [31:0] rd;
    logic        b;

    quick_spi_target dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .txdata_valid_i(tx_valid), .txdata_ready_o(tx_ready), .txdata_i(tx_data),
        .rxdata_valid_o(rx_valid), .rxdata_ready_i(rx_ready), .rxdata_o(rx_data),
        .rxdata_len_o(rx_len), .rx_overflow_o(rx_ovf), .tx_underrun_o(tx_und),
        .sclk_i(sclk), .cs_n_i(cs_n), .sdata_i(sdi), .sdata_o(sdo), .sdata_oe_o(sdo_oe)
    );

    always #5 clk = ~clk;

    // Count one-cycle pulses
    always @(posedge clk) begin
        if (tx_und) n_under <= n_under + 1;
        if (rx_ovf) n_ovf <= n_ovf + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sbit(input logic bi, output logic ro);
        sclk = 0;
        sdi = bi;
        repeat (4) @(negedge clk);
        sclk = 1;
        ro = sdo;
        repeat (4) @(negedge clk);
    endtask

    task automatic xfer(input logic [31:0] w, input int n, output logic [31:0] r);
        logic bo;
        r = 0;
        cs_n = 0;
        repeat (6) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            sbit(w[i], bo);
            r = {r[30:0], bo};
        end
        check("oe_active", {31'd0, sdo_oe}, 32'd1);
        cs_n = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] w);
        tx_valid = 1;
        tx_data = w;
        @(negedge clk);
        tx_valid = 0;
        check("tx_ready_low", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic accept();
        rx_ready = 1;
        @(negedge clk);
        rx_ready = 0;
        @(negedge clk);
        check("rx_valid_cleared", {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_rx_data"}, {16'd0, rx_data}, 32'd0);
        check({tag, "_rx_len"}, {27'd0, rx_len}, 32'd0);
        check({tag, "_sdo"}, {31'd0, sdo}, 32'd0);
        check({tag, "_oe"}, {31'd0, sdo_oe}, 32'd0);
        check({tag, "_pulses"}, {30'd0, rx_ovf, tx_und}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_outputs("rst");
        rst_n = 1;
        repeat (3) @(negedge clk);

        // T1: preloaded TX word, full 16-bit exchange
        load(16'hA5C3);
        u0 = n_under;
        xfer(32'h1234, 16, rd);
        check("t1_miso", rd, 32'hA5C3);
        check("t1_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("t1_rx_data", {16'd0, rx_data}, 32'h1234);
        check("t1_rx_len", {27'd0, rx_len}, 32'd16);
        check("t1_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("t1_no_underrun", n_under - u0, 0);
        check("t1_oe_idle", {31'd0, sdo_oe}, 32'd0);
        accept();

        // T2: empty TX register, 8-bit exchange
        u0 = n_under;
        xfer(32'h5A, 8, rd);
        check("t2_underrun", n_under - u0, 1);
        check("t2_miso", rd, 32'h00);
        check("t2_rx_data", {24'd0, rx_data[7:0]}, 32'h5A);
        check("t2_rx_len", {27'd0, rx_len}, 32'd8);
        accept();

        // T3: second result arrives while first is unaccepted
        load(16'hBEEF);
        o0 = n_ovf;
        xfer(32'h1111, 16, rd);
        check("t3_miso", rd, 32'hBEEF);
        xfer(32'h22, 8, rd);
        check("t3_overflow", n_ovf - o0, 1);
        check("t3_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("t3_rx_kept", {16'd0, rx_data}, 32'h1111);
        check("t3_len_kept", {27'd0, rx_len}, 32'd16);
        accept();

        // T4: 20 rises in one window; count saturates, last 16 bits kept
        o0 = n_ovf;
        xfer(32'hABCDE, 20, rd);
        check("t4_rx_data", {16'd0, rx_data}, 32'hBCDE);
        check("t4_rx_len", {27'd0, rx_len}, 32'd16);
        check("t4_no_overflow", n_ovf - o0, 0);
        accept();

        // T5: CS pulse with no SCLK consumes TX word, posts nothing
        load(16'h7777);
        u0 = n_under;
        cs_n = 0;
        repeat (8) @(negedge clk);
        cs_n = 1;
        repeat (6) @(negedge clk);
        check("t5_no_rx", {31'd0, rx_valid}, 32'd0);
        check("t5_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("t5_no_underrun", n_under - u0, 0);
        check("t5_oe", {31'd0, sdo_oe}, 32'd0);

        // T6: reset after 5 bits, then a clean transfer
        load(16'hC0DE);
        cs_n = 0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) sbit(1'b1, b);
        check("t6_oe_before_rst", {31'd0, sdo_oe}, 32'd1);
        rst_n = 0;
        repeat (2) @(negedge clk);
        reset_outputs("t6");
        cs_n = 1;
        sclk = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("t6_no_rx", {31'd0, rx_valid}, 32'd0);
        load(16'h1357);
        xfer(32'h2468, 16, rd);
        check("t6_miso", rd, 32'h1357);
        check("t6_rx_data", {16'd0, rx_data}, 32'h2468);
        check("t6_rx_len", {27'd0, rx_len}, 32'd16);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
